// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit with HI/LO registers.
//
// Decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO directly from op/func and runs a
// WIDTH-iteration shift-add multiplier / restoring divider. While an operation is in flight
// o_stall is raised so the top level can gate the controller/PC enable.
//
// Ports:
//   i_clk       rising-edge clock
//   i_reset     asynchronous, active-high reset
//   i_enable    global run enable (pre-stall); 0 freezes all state
//   i_op        instruction opcode
//   i_func      instruction func field
//   i_rs_val    rs value (dividend / multiplicand / MTHI,MTLO data)
//   i_rt_val    rt value (divisor / multiplier)
//   o_stall     1 = hold PC/instruction
//   o_hilo_out  HI when func==MFHI, else LO (combinational)
//   o_busy      engine is iterating or fixing up a result
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [5:0]       i_op,
    input  logic [5:0]       i_func,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_hilo_out,
    output logic             o_busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // mult: {partial product, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   r_opd;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_rs;
    logic               r_neg_rt;
    logic               r_dvz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_stall;

    // Decode
    logic w_op_rtype;
    logic w_dec_md;
    logic w_dec_signed;
    logic w_dec_div;
    logic w_stall_live;

    assign w_op_rtype   = (i_op == 6'd0);
    assign w_dec_md     = w_op_rtype &&
                          (i_func == FnMult || i_func == FnMultu ||
                           i_func == FnDiv  || i_func == FnDivu);
    assign w_dec_signed = ~i_func[0];
    assign w_dec_div    = i_func[1];

    // Operand magnitudes for the issue cycle
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;

    assign w_rs_neg = w_dec_signed & i_rs_val[WIDTH-1];
    assign w_rt_neg = w_dec_signed & i_rt_val[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -i_rs_val : i_rs_val;
    assign w_rt_mag = w_rt_neg ? -i_rt_val : i_rt_val;

    // Multiply step: add multiplicand if lsb set, then shift the whole accumulator right
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_add_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_addend   = r_acc[0] ? {1'b0, r_opd} : '0;
    assign w_add_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_mul_next = {w_add_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into remainder, trial-subtract divisor
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_opd};
    assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign fix-up
    logic               w_neg_res;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_neg_res  = r_neg_rs ^ r_neg_rt;
    assign w_prod_fix = w_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rs ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign w_stall_live = (r_state == StIter) || (r_state == StFix) ||
                          ((r_state == StIdle) && w_dec_md);

    // While frozen, stall holds the value it had at the last enabled edge
    assign o_stall    = i_reset ? 1'b0 : (i_enable ? w_stall_live : r_stall);
    assign o_busy     = (r_state == StIter) || (r_state == StFix);
    assign o_hilo_out = (i_func == FnMfhi) ? r_hi : r_lo;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_is_div <= 1'b0;
            r_neg_rs <= 1'b0;
            r_neg_rt <= 1'b0;
            r_dvz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_stall  <= 1'b0;
        end else if (i_enable) begin
            r_stall <= w_stall_live;
            case (r_state)
                StIdle: begin
                    if (w_dec_md) begin
                        r_is_div <= w_dec_div;
                        r_neg_rs <= w_rs_neg;
                        r_neg_rt <= w_rt_neg;
                        r_dvz    <= (i_rt_val == '0);
                        r_opd    <= w_dec_div ? w_rt_mag : w_rs_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (w_dec_div ? w_rs_mag : w_rt_mag)};
                        r_cnt    <= '0;
                        r_state  <= StIter;
                    end else if (w_op_rtype && i_func == FnMthi) begin
                        r_hi <= i_rs_val;
                    end else if (w_op_rtype && i_func == FnMtlo) begin
                        r_lo <= i_rs_val;
                    end
                end
                StIter: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == CntW'(WIDTH - 1)) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    if (r_is_div) begin
                        // A zero divisor never fails the trial subtract, so the remainder
                        // ends up as |rs| and the sign fix restores the raw dividend.
                        r_hi <= w_rem_fix;
                        r_lo <= r_dvz ? {WIDTH{1'b1}} : w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_state <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
